// File: rtl/mem_rr_arbiter_if.sv
// Bundle of requester, memory and response signals around the round-robin read arbiter.
// Latency: none, signal container only.
// Backpressure: mem_ready from memory gates every grant; responses cannot be stalled.
interface mem_rr_arbiter_if #(
    parameter int N_REQ             = 4,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 20
);
    logic                                 flush;
    logic [N_REQ-1:0]                     req_valid;
    logic [N_REQ*MEMORY_ADDR_WIDTH-1:0]   req_addr;
    logic [N_REQ-1:0]                     req_ready;
    logic                                 mem_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr;
    logic                                 mem_ready;
    logic [MEMORY_WIDTH-1:0]              mem_data;
    logic [N_REQ-1:0]                     rsp_valid;
    logic [MEMORY_WIDTH-1:0]              rsp_data;
    logic                                 busy;

    // arbiter side
    modport slave (
        input  flush, req_valid, req_addr, mem_ready, mem_data,
        output req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, busy
    );

    // requesters + memory side
    modport master (
        output flush, req_valid, req_addr, mem_ready, mem_data,
        input  req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one read port among N_REQ requesters, steering returned data by id.
// Latency: grant is combinational; response appears exactly READ_LATENCY cycles after acceptance.
// Backpressure: mem_ready low holds the grant and the round-robin pointer; responses cannot stall.
module mem_rr_arbiter #(
    parameter int N_REQ             = 4,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 20,
    parameter int READ_LATENCY      = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_rr_arbiter_if.slave bus
);
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             winner;
    logic [PW-1:0]             ptr_next;
    logic                      any_req;
    logic                      handshake;
    int                        scan_idx;
    logic                      found;
    logic [READ_LATENCY-1:0]   pipe_vld;
    logic [PW-1:0]             pipe_id [READ_LATENCY];
    logic [MEMORY_WIDTH-1:0]   rd_data;

    assign any_req   = |bus.req_valid;
    assign handshake = any_req && bus.mem_ready;
    assign ptr_next  = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

    // Pick the first valid requester starting from rr_ptr and wrapping around.
    always_comb begin
        winner   = rr_ptr;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = PW'(scan_idx);
            end
        end
    end

    // Drive the memory address and the one-hot grant for the winner.
    always_comb begin
        bus.mem_valid = any_req;
        bus.mem_addr  = any_req ? bus.req_addr[int'(winner) * AW +: AW] : '0;
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_ready[i] = handshake && (int'(winner) == i);
        end
    end

    // Advance the pointer past the winner only when memory takes the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= ptr_next;
        end
    end

    // In-flight tracker: one stage per cycle of read latency; flush kills every stage, including this cycle's accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= handshake && !bus.flush;
            pipe_id[0]  <= winner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] && !bus.flush;
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    // Steer returning data to the requester recorded in the last stage; flush suppresses it.
    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.rsp_valid[i] = pipe_vld[READ_LATENCY-1] && !bus.flush &&
                               (int'(pipe_id[READ_LATENCY-1]) == i);
        end
    end

    assign rd_data      = bus.mem_data;
    assign bus.rsp_data = rd_data;
    assign bus.busy     = |pipe_vld;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: three instances (read latency 2, 1, 8) share one stimulus stream.
// A scoreboard records every accepted request and expects its response at the exact latency per instance.
// Directed tasks cover round robin, stall, wrap, flush, asynchronous reset and random traffic.
module tb_mem_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 20;
    localparam int NL = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic            mem_ready = 1'b0;
    logic [DW-1:0]   mem_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int m_ptr = 0;

    typedef struct {
        int id;
        int cyc;
    } acc_t;
    acc_t acc_q[$];
    int   rd[NL];

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW)) bus2();
    mem_rr_arbiter_if #(.N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW)) bus1();
    mem_rr_arbiter_if #(.N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW)) bus8();

    assign bus2.flush = flush;  assign bus2.req_valid = req_valid;  assign bus2.req_addr = req_addr;
    assign bus2.mem_ready = mem_ready;  assign bus2.mem_data = mem_data;
    assign bus1.flush = flush;  assign bus1.req_valid = req_valid;  assign bus1.req_addr = req_addr;
    assign bus1.mem_ready = mem_ready;  assign bus1.mem_data = mem_data;
    assign bus8.flush = flush;  assign bus8.req_valid = req_valid;  assign bus8.req_addr = req_addr;
    assign bus8.mem_ready = mem_ready;  assign bus8.mem_data = mem_data;

    mem_rr_arbiter #(.N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW), .READ_LATENCY(2))
        u_dut  (.clk(clk), .rst(rst), .bus(bus2.slave));
    mem_rr_arbiter #(.N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW), .READ_LATENCY(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_rr_arbiter #(.N_REQ(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW), .READ_LATENCY(8))
        u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    logic [N-1:0]  rsp_v  [NL];
    logic          busy_v [NL];
    logic [DW-1:0] rsp_d  [NL];
    assign rsp_v[0] = bus2.rsp_valid;  assign busy_v[0] = bus2.busy;  assign rsp_d[0] = bus2.rsp_data;
    assign rsp_v[1] = bus1.rsp_valid;  assign busy_v[1] = bus1.busy;  assign rsp_d[1] = bus1.rsp_data;
    assign rsp_v[2] = bus8.rsp_valid;  assign busy_v[2] = bus8.busy;  assign rsp_d[2] = bus8.rsp_data;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int model_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        logic [N*AW-1:0] a;
        a = req_addr;
        return a[i*AW +: AW];
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic fl);
        @(negedge clk);
        req_valid = v;
        mem_ready = rdy;
        flush     = fl;
        mem_data  = DW'($urandom);
    endtask

    // Scoreboard: records accepts at each rising edge, checks every instance's response and busy each cycle.
    task automatic sb_run();
        acc_t         e;
        logic [N-1:0] exp_rsp;
        logic         pending;
        int           w;
        forever begin
            @(posedge clk);
            if (rst) begin
                acc_q.delete();
                for (int k = 0; k < NL; k++) rd[k] = 0;
                m_ptr = 0;
            end else begin
                if (flush) begin
                    acc_q.delete();
                    for (int k = 0; k < NL; k++) rd[k] = 0;
                end
                if ((|req_valid) && mem_ready) begin
                    w = model_winner(req_valid, m_ptr);
                    m_ptr = (w + 1) % N;
                    if (!flush) begin
                        e.id = w;
                        e.cyc = cyc;
                        acc_q.push_back(e);
                    end
                end
            end
            cyc++;
            @(negedge clk);
            #2;
            for (int k = 0; k < NL; k++) begin
                pending = (rd[k] < acc_q.size());
                n_cmp++;
                if (busy_v[k] !== (pending && !rst)) begin
                    n_bad++;
                    $display("FAIL sb_busy lat%0d cyc %0d: got %b expected %b", lat_of(k), cyc, busy_v[k], pending && !rst);
                end
                exp_rsp = '0;
                if (!rst && pending && (acc_q[rd[k]].cyc + lat_of(k) == cyc)) begin
                    if (!flush) exp_rsp = N'(1 << acc_q[rd[k]].id);
                    rd[k]++;
                end
                n_cmp++;
                if (rsp_v[k] !== exp_rsp) begin
                    n_bad++;
                    $display("FAIL sb_rsp lat%0d cyc %0d: got %b expected %b", lat_of(k), cyc, rsp_v[k], exp_rsp);
                end
                n_cmp++;
                if (rsp_d[k] !== mem_data) begin
                    n_bad++;
                    $display("FAIL sb_data lat%0d: got %h expected %h", lat_of(k), rsp_d[k], mem_data);
                end
            end
            while (acc_q.size() > 0 && rd[0] > 0 && rd[1] > 0 && rd[2] > 0) begin
                acc_q.delete(0);
                for (int k = 0; k < NL; k++) rd[k]--;
            end
        end
    endtask

    task automatic test_reset();
        drive('0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus2.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b expected 0000", bus2.req_ready); end
        n_cmp++; if (bus2.mem_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_valid: got %b expected 0", bus2.mem_valid); end
        n_cmp++; if (bus2.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus2.busy); end
        n_cmp++; if (bus2.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp: got %b expected 0000", bus2.rsp_valid); end
        drive('0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus2.mem_addr !== '0) begin n_bad++; $display("FAIL idle_addr: got %h expected 0", bus2.mem_addr); end
        drive(4'b1111, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus2.req_ready !== 4'b0000) begin n_bad++; $display("FAIL noready_grant: got %b expected 0000", bus2.req_ready); end
        n_cmp++; if (bus2.mem_valid !== 1'b1) begin n_bad++; $display("FAIL noready_valid: got %b expected 1", bus2.mem_valid); end
        n_cmp++; if (bus2.mem_addr !== addr_of(0)) begin n_bad++; $display("FAIL noready_addr: got %h expected %h", bus2.mem_addr, addr_of(0)); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(4'b1111, 1'b1, 1'b0);
            else drive(4'b0000, 1'b0, 1'b0);
            #1;
            exp = (k < 8) ? N'(1 << (k % 4)) : '0;
            n_cmp++;
            if (bus2.req_ready !== exp) begin n_bad++; $display("FAIL rr_grant %0d: got %b expected %b", k, bus2.req_ready, exp); end
            if (k < 8) begin
                n_cmp++;
                if (bus2.mem_addr !== addr_of(k % 4)) begin n_bad++; $display("FAIL rr_addr %0d: got %h expected %h", k, bus2.mem_addr, addr_of(k % 4)); end
            end
            exp = (k >= 2) ? N'(1 << ((k - 2) % 4)) : '0;
            n_cmp++;
            if (bus2.rsp_valid !== exp) begin n_bad++; $display("FAIL rr_rsp %0d: got %b expected %b", k, bus2.rsp_valid, exp); end
        end
    endtask

    task automatic test_stall_and_wrap();
        logic [N-1:0] exp_seq [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 1'b0, 1'b0);
            #1;
            n_cmp++; if (bus2.req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_grant %0d: got %b expected 0000", k, bus2.req_ready); end
            n_cmp++; if (bus2.mem_addr !== addr_of(2)) begin n_bad++; $display("FAIL stall_addr %0d: got %h expected %h", k, bus2.mem_addr, addr_of(2)); end
        end
        drive(4'b0100, 1'b1, 1'b0);
        #1;
        n_cmp++; if (bus2.req_ready !== 4'b0100) begin n_bad++; $display("FAIL stall_release: got %b expected 0100", bus2.req_ready); end
        drive(4'b1111, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus2.mem_addr !== addr_of(3)) begin n_bad++; $display("FAIL ptr_is_3: got %h expected %h", bus2.mem_addr, addr_of(3)); end
        for (int k = 0; k < 4; k++) begin
            drive(4'b0011, 1'b1, 1'b0);
            #1;
            n_cmp++;
            if (bus2.req_ready !== exp_seq[k]) begin n_bad++; $display("FAIL wrap_grant %0d: got %b expected %b", k, bus2.req_ready, exp_seq[k]); end
        end
        drive(4'b1111, 1'b1, 1'b0);
        #1;
        n_cmp++; if (bus2.req_ready !== 4'b0100) begin n_bad++; $display("FAIL wrap_after: got %b expected 0100", bus2.req_ready); end
        for (int k = 0; k < 10; k++) drive(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        #1;
        n_cmp++; if (bus2.req_ready !== 4'b0010) begin n_bad++; $display("FAIL flush_setup: got %b expected 0010", bus2.req_ready); end
        drive(4'b0100, 1'b1, 1'b1);
        #1;
        n_cmp++; if (bus2.req_ready !== 4'b0100) begin n_bad++; $display("FAIL flush_accept: got %b expected 0100", bus2.req_ready); end
        n_cmp++; if (bus2.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL flush_rsp: got %b expected 0000", bus2.rsp_valid); end
        n_cmp++; if (bus2.busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before: got %b expected 1", bus2.busy); end
        for (int k = 0; k < 3; k++) begin
            drive(4'b0000, 1'b0, 1'b0);
            #1;
            n_cmp++; if (bus2.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after %0d: got %b expected 0", k, bus2.busy); end
            n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy8 %0d: got %b expected 0", k, bus8.busy); end
            n_cmp++; if (bus2.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL flush_rsp_after %0d: got %b expected 0000", k, bus2.rsp_valid); end
        end
    endtask

    task automatic test_async_reset();
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus2.busy !== 1'b1) begin n_bad++; $display("FAIL ar_busy_pre: got %b expected 1", bus2.busy); end
        n_cmp++; if (bus8.busy !== 1'b1) begin n_bad++; $display("FAIL ar_busy8_pre: got %b expected 1", bus8.busy); end
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NL; k++) begin
            n_cmp++; if (busy_v[k] !== 1'b0) begin n_bad++; $display("FAIL ar_busy lat%0d: got %b expected 0", lat_of(k), busy_v[k]); end
            n_cmp++; if (rsp_v[k] !== 4'b0000) begin n_bad++; $display("FAIL ar_rsp lat%0d: got %b expected 0000", lat_of(k), rsp_v[k]); end
        end
        drive(4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        drive(4'b1111, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus2.mem_addr !== addr_of(0)) begin n_bad++; $display("FAIL ar_ptr0: got %h expected %h", bus2.mem_addr, addr_of(0)); end
        for (int k = 0; k < 12; k++) begin
            drive(4'b0000, 1'b0, 1'b0);
            #1;
            n_cmp++; if (bus8.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL ar_stale %0d: got %b expected 0000", k, bus8.rsp_valid); end
        end
    endtask

    task automatic test_traffic();
        logic [N-1:0] v;
        logic         rdy;
        logic [N-1:0] exp;
        int           n_acc = 0;
        int           n_rsp [NL] = '{0, 0, 0};
        for (int c = 0; c < 412; c++) begin
            if (c < 400) begin
                v   = N'($urandom_range(0, 15));
                rdy = ($urandom_range(0, 3) != 0);
                req_addr = {$urandom, $urandom};
            end else begin
                v   = '0;
                rdy = 1'b0;
            end
            drive(v, rdy, 1'b0);
            #1;
            exp = ((|v) && rdy) ? N'(1 << model_winner(v, m_ptr)) : '0;
            if (exp != '0) n_acc++;
            n_cmp++;
            if (bus2.req_ready !== exp) begin n_bad++; $display("FAIL tr_grant %0d: got %b expected %b", c, bus2.req_ready, exp); end
            if (|v) begin
                n_cmp++;
                if (bus8.mem_addr !== addr_of(model_winner(v, m_ptr))) begin
                    n_bad++; $display("FAIL tr_addr %0d: got %h expected %h", c, bus8.mem_addr, addr_of(model_winner(v, m_ptr)));
                end
            end
            for (int k = 0; k < NL; k++) n_rsp[k] += $countones(rsp_v[k]);
        end
        for (int k = 0; k < NL; k++) begin
            n_cmp++;
            if (n_rsp[k] !== n_acc) begin n_bad++; $display("FAIL tr_count lat%0d: got %0d expected %0d", lat_of(k), n_rsp[k], n_acc); end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(11'h040 * i + 11'h007);
        fork
            sb_run();
        join_none
        test_reset();
        test_round_robin();
        test_stall_and_wrap();
        test_flush();
        test_async_reset();
        test_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
